// File: rtl/icache_ctrl_pkg.sv
// Shared geometry, FSM encoding and address helper for the instruction cache.
package icache_ctrl_pkg;

  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned TAG_W          = 7;
  localparam int unsigned INDEX_W        = 5;
  localparam int unsigned OFFSET_W       = 3;
  localparam int unsigned NUM_SETS       = 32;
  localparam int unsigned WORDS_PER_LINE = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Halfword-aligned byte address of one word within a line.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0]    tag,
                                                  input logic [INDEX_W-1:0]  idx,
                                                  input logic [OFFSET_W-1:0] off);
    return {tag, idx, off, 1'b0};
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction cache data storage: NUM_SETS x WORDS_PER_LINE words.
// Ports: clk; write port (we_i, wr_idx_i, wr_off_i, wr_data_i) sampled on
// the rising edge; asynchronous read port (rd_idx_i, rd_off_i -> rd_data_o).
// Contents are deliberately not reset; validity is tracked by the controller.
module icache_data_array
  import icache_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                we_i,
  input  logic [INDEX_W-1:0]  wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  localparam int unsigned DEPTH = NUM_SETS * WORDS_PER_LINE;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller (32 sets x 8 halfwords).
// Ports: clk, rst (sync, active-low); fetch side fetch_req/fetch_addr in,
// instr/instr_valid/stall out (combinational lookup result); memory side
// mem_req/mem_addr out, mem_data/mem_data_valid in (one word per request).
// Hits are answered in the same cycle; a miss stalls and fills the whole
// line word by word before the lookup is retried from IDLE.
module icache_ctrl
  import icache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid
);

  state_e                state_q;
  logic [TAG_W-1:0]      miss_tag_q;
  logic [INDEX_W-1:0]    miss_idx_q;
  logic [OFFSET_W-1:0]   cnt_q;
  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q [NUM_SETS];

  logic [TAG_W-1:0]      f_tag;
  logic [INDEX_W-1:0]    f_idx;
  logic [OFFSET_W-1:0]   f_off;
  logic                  fetch_lsb_unused;
  logic                  lookup_hit;
  logic                  fill_ack;
  logic                  fill_last;
  logic [DATA_W-1:0]     rd_data;

  assign f_tag            = fetch_addr[15:9];
  assign f_idx            = fetch_addr[8:4];
  assign f_off            = fetch_addr[3:1];
  assign fetch_lsb_unused = fetch_addr[0];

  assign lookup_hit = (state_q == IDLE) && fetch_req && valid_q[f_idx] &&
                      (tag_q[f_idx] == f_tag);
  // Returned words only count while a request is actually outstanding.
  assign fill_ack   = (state_q == FILL) && mem_data_valid && rst;
  assign fill_last  = (cnt_q == OFFSET_W'(WORDS_PER_LINE - 1));

  assign instr       = rd_data;
  assign instr_valid = lookup_hit;
  assign stall       = (state_q == FILL) || (fetch_req && !lookup_hit);
  assign mem_req     = (state_q == FILL);
  assign mem_addr    = mem_req ? word_addr(miss_tag_q, miss_idx_q, cnt_q) : '0;

  // Control FSM: miss latch, word counter and line valid bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req && !lookup_hit) begin
            miss_tag_q <= f_tag;
            miss_idx_q <= f_idx;
            cnt_q      <= '0;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (mem_data_valid) begin
            cnt_q <= OFFSET_W'(cnt_q + 1'b1);
            if (fill_last) begin
              valid_q[miss_idx_q] <= 1'b1;
              state_q             <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Tag written only once the whole line has arrived; not reset.
  always_ff @(posedge clk) begin
    if (fill_ack && fill_last) begin
      tag_q[miss_idx_q] <= miss_tag_q;
    end
  end

  icache_data_array u_data (
    .clk       (clk),
    .we_i      (fill_ack),
    .wr_idx_i  (miss_idx_q),
    .wr_off_i  (cnt_q),
    .wr_data_i (mem_data),
    .rd_idx_i  (f_idx),
    .rd_off_i  (f_off),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl; memory answers 3 cycles after a request
// with data = ~address.
module tb_icache_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;

  int total = 0;
  int bad   = 0;

  icache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_hit(input string tag, input logic [15:0] exp);
    chk({tag, "_instr"}, instr, exp);
    chk({tag, "_valid"}, 16'(instr_valid), 16'h1);
    chk({tag, "_stall"}, 16'(stall), 16'h0);
  endtask

  task automatic chk_miss(input string tag);
    chk({tag, "_stall"}, 16'(stall), 16'h1);
    chk({tag, "_valid"}, 16'(instr_valid), 16'h0);
  endtask

  // Advance to the next sampling point and present a fetch.
  task automatic lookup(input logic [15:0] addr);
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    #1;
  endtask

  // Serve words first..first+n-1 of the line at base, checking each request.
  task automatic fill_words(input logic [15:0] base, input int first, input int n);
    for (int w = first; w < first + n; w++) begin
      int waited = 0;
      while (mem_req !== 1'b1 && waited < 20) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("req_seen", 16'(mem_req), 16'h1);
      chk("req_addr", mem_addr, 16'(base + 16'(2 * w)));
      chk("fill_stall", 16'(stall), 16'h1);
      chk("fill_ivalid", 16'(instr_valid), 16'h0);
      repeat (3) @(negedge clk);
      mem_data       = ~mem_addr;
      mem_data_valid = 1'b1;
      @(negedge clk);
      mem_data_valid = 1'b0;
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    fetch_req      = 1'b0;
    fetch_addr     = 16'h0000;
    mem_data       = 16'h0000;
    mem_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ivalid", 16'(instr_valid), 16'h0);
    chk("rst_stall", 16'(stall), 16'h0);
    fetch_req = 1'b1;
    #1;
    chk_miss("rst_fetch");

    // Cold miss on line 0, full fill, then same-line hits.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_miss("miss0");
    fill_words(16'h0000, 0, 8);
    chk("fill0_mem_req", 16'(mem_req), 16'h0);
    chk_hit("fill0", 16'hFFFF);
    lookup(16'h0006);
    chk_hit("hit6", 16'hFFF9);
    lookup(16'h000E);
    chk_hit("hitE", 16'hFFF1);

    @(negedge clk);
    fetch_req = 1'b0;
    #1;
    chk("nofetch_ivalid", 16'(instr_valid), 16'h0);
    chk("nofetch_stall", 16'(stall), 16'h0);
    chk("nofetch_mem_req", 16'(mem_req), 16'h0);

    // Stray memory response in IDLE must change nothing.
    @(negedge clk);
    mem_data       = 16'h1234;
    mem_data_valid = 1'b1;
    #1;
    chk("stray_mem_req", 16'(mem_req), 16'h0);
    @(negedge clk);
    mem_data_valid = 1'b0;
    lookup(16'h0000);
    chk_hit("after_stray", 16'hFFFF);

    // Reset after three words of the line at 0x0010 aborts the fill.
    lookup(16'h0010);
    chk_miss("miss10");
    fill_words(16'h0010, 0, 3);
    rst       = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_mem_req", 16'(mem_req), 16'h0);
    chk("abort_mem_addr", mem_addr, 16'h0000);
    chk("abort_stall", 16'(stall), 16'h0);
    rst            = 1'b1;
    mem_data       = 16'h1234;
    mem_data_valid = 1'b1;
    @(negedge clk);
    mem_data_valid = 1'b0;
    #1;
    chk("late_mem_req", 16'(mem_req), 16'h0);
    lookup(16'h0000);
    chk_miss("postrst0");
    fill_words(16'h0000, 0, 8);
    chk_hit("refill0", 16'hFFFF);
    lookup(16'h0010);
    chk_miss("postrst10");
    fill_words(16'h0010, 0, 8);
    chk_hit("refill10", 16'hFFEF);
    lookup(16'h0014);
    chk_hit("hit14", 16'hFFEB);

    // Conflict on index 0 evicts and refills.
    lookup(16'h0200);
    chk_miss("miss200");
    fill_words(16'h0200, 0, 8);
    chk_hit("fill200", 16'hFDFF);
    lookup(16'h0000);
    chk_miss("evict0");
    fill_words(16'h0000, 0, 8);
    chk_hit("refetch0", 16'hFFFF);

    // Fetch changes mid-fill are ignored until the line completes.
    lookup(16'h0040);
    chk_miss("miss40");
    fill_words(16'h0040, 0, 2);
    fetch_addr = 16'h0080;
    fetch_req  = 1'b0;
    fill_words(16'h0040, 2, 3);
    fetch_req = 1'b1;
    fill_words(16'h0040, 5, 3);
    chk_miss("miss80");
    chk("miss80_mem_req", 16'(mem_req), 16'h0);
    fill_words(16'h0080, 0, 8);
    chk_hit("fill80", 16'hFF7F);
    lookup(16'h0040);
    chk_hit("hit40", 16'hFFBF);
    lookup(16'h0000);
    chk_hit("hit0_end", 16'hFFFF);

    @(negedge clk);
    fetch_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
